team_wb_regbank: RTL and testbench

//  Parametrised Wishbone slave register bank that sits between the chip-level wrapper and a team design.

---
 rtl/team_wb_pkg.sv | 50 +++++
 rtl/team_wb_irq_ctrl.sv | 47 ++++
 rtl/team_wb_regbank.sv | 222 ++++++++++++++++++++++
 tb/tb_team_wb_regbank.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/team_wb_pkg.sv
// Shared definitions for the team Wishbone register bank:
// word offsets, bus width, access kinds and byte-lane helper.
package team_wb_pkg;

  localparam int WB_DW = 32;

  localparam int unsigned OFF_GPIO_OUT_LO = 0;
  localparam int unsigned OFF_GPIO_OUT_HI = 1;
  localparam int unsigned OFF_GPIO_OEB_LO = 2;
  localparam int unsigned OFF_GPIO_OEB_HI = 3;
  localparam int unsigned OFF_GPIO_IN_LO  = 4;
  localparam int unsigned OFF_GPIO_IN_HI  = 5;
  localparam int unsigned OFF_IRQ_STATUS  = 6;
  localparam int unsigned OFF_IRQ_MASK    = 7;
  localparam int unsigned OFF_USER_BASE   = 8;

  typedef enum logic [1:0] {
    RW,
    RO,
    W1C
  } acc_e;

  // Unmapped offsets behave as read-only zero.
  function automatic acc_e off_acc(
    input logic [31:0] off,
    input int unsigned nregs
  );
    acc_e a;
    a = RO;
    if (off == OFF_GPIO_IN_LO || off == OFF_GPIO_IN_HI)
      a = RO;
    else if (off == OFF_IRQ_STATUS)
      a = W1C;
    else if (off < OFF_USER_BASE)
      a = RW;
    else if (off - OFF_USER_BASE < nregs)
      a = RW;
    return a;
  endfunction

  function automatic logic [WB_DW-1:0] lane_mask(
    input logic [3:0] sel
  );
    logic [WB_DW-1:0] m;
    for (int b = 0; b < 4; b++)
      m[8*b +: 8] = {8{sel[b]}};
    return m;
  endfunction

endpackage

// File: rtl/team_wb_irq_ctrl.sv
// Interrupt controller: rising-edge capture into sticky
// STATUS, write-one-to-clear, MASK, registered irq_o.
module team_wb_irq_ctrl #(
  parameter int NUM_IRQ = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_IRQ-1:0] src_i,
  input  logic               mask_we_i,
  input  logic [NUM_IRQ-1:0] mask_wd_i,
  input  logic [NUM_IRQ-1:0] clr_i,
  output logic [NUM_IRQ-1:0] status_o,
  output logic [NUM_IRQ-1:0] mask_o,
  output logic [NUM_IRQ-1:0] irq_o
);

  logic [NUM_IRQ-1:0] src_q;
  logic [NUM_IRQ-1:0] status_q, status_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic [NUM_IRQ-1:0] irq_q;

  // A new edge is OR-ed in after the clear so it wins.
  always_comb begin
    status_d = (status_q & ~clr_i) | (src_i & ~src_q);
    mask_d   = mask_we_i ? mask_wd_i : mask_q;
  end

  // Edge history, sticky status, mask and output line.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q    <= '0;
      status_q <= '0;
      mask_q   <= '0;
      irq_q    <= '0;
    end else begin
      src_q    <= src_i;
      status_q <= status_d;
      mask_q   <= mask_d;
      irq_q    <= status_q & mask_q;
    end
  end

  assign status_o = status_q;
  assign mask_o   = mask_q;
  assign irq_o    = irq_q;

endmodule

// File: rtl/team_wb_regbank.sv
// Wishbone classic slave: GPIO, IRQ and user registers.
// Optional WB_BYTE_SEL_EN: honour sel_i byte lanes on writes.
module team_wb_regbank
  import team_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int WIN_BITS = 8,
  parameter int NUM_REGS = 8,
  parameter int NUM_IRQ  = 3,
  parameter int GPIO_W   = 34
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ncs,
  input  logic [31:0]           adr_i,
  input  logic [31:0]           dat_i,
  input  logic [3:0]            sel_i,
  input  logic                  we_i,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  output logic                  ack_o,
  output logic [31:0]           dat_o,
  input  logic [GPIO_W-1:0]     gpio_in,
  output logic [GPIO_W-1:0]     gpio_out,
  output logic [GPIO_W-1:0]     gpio_oeb,
  input  logic [NUM_IRQ-1:0]    irq_src_i,
  output logic [NUM_REGS*32-1:0] usr_reg_o,
  output logic [NUM_REGS-1:0]   usr_wr_o,
  output logic [NUM_IRQ-1:0]    irq_o
);

  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic [GPIO_W-1:0] gout_q, gout_d;
  logic [GPIO_W-1:0] goeb_q, goeb_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [31:0]       usr_q [NUM_REGS];
  logic [31:0]       usr_d [NUM_REGS];
  logic [NUM_REGS-1:0] uwr_q, uwr_d;

  logic        in_win, req, wr;
  logic [31:0] off, lmask, rdat;
  acc_e        acc;
  logic [63:0] gout64, goeb64, gin64;
  logic [63:0] gout_w, goeb_w;
  logic [31:0] stat32, mask32;
  logic [31:0] clr_w, mask_w;
  logic [NUM_IRQ-1:0] status, mask;
  logic [NUM_IRQ-1:0] irq_clr;
  logic        mask_we;
  logic        unused;

  assign in_win = adr_i[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS];
  assign req = cyc_i & stb_i & ~ncs & in_win & ~ack_q;
  assign off = 32'(adr_i[WIN_BITS-1:2]);
  assign acc = off_acc(off, NUM_REGS);
  assign wr  = req & we_i & (acc != RO);

`ifdef WB_BYTE_SEL_EN
  assign lmask = lane_mask(sel_i);
`else
  assign lmask = '1;
`endif

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [31:0] m
  );
    return (old & ~m) | (nw & m);
  endfunction

  // Zero-extend narrow registers to full readable words.
  always_comb begin
    gout64 = '0;
    goeb64 = '0;
    gin64  = '0;
    stat32 = '0;
    mask32 = '0;
    gout64[GPIO_W-1:0]  = gout_q;
    goeb64[GPIO_W-1:0]  = goeb_q;
    gin64[GPIO_W-1:0]   = sync2_q;
    stat32[NUM_IRQ-1:0] = status;
    mask32[NUM_IRQ-1:0] = mask;
  end

  // GPIO write path; bits above GPIO_W fall away.
  always_comb begin
    gout_w = gout64;
    goeb_w = goeb64;
    if (wr) begin
      case (off)
        OFF_GPIO_OUT_LO:
          gout_w[31:0] = merge(gout64[31:0], dat_i, lmask);
        OFF_GPIO_OUT_HI:
          gout_w[63:32] = merge(gout64[63:32], dat_i, lmask);
        OFF_GPIO_OEB_LO:
          goeb_w[31:0] = merge(goeb64[31:0], dat_i, lmask);
        OFF_GPIO_OEB_HI:
          goeb_w[63:32] = merge(goeb64[63:32], dat_i, lmask);
        default: ;
      endcase
    end
    gout_d = gout_w[GPIO_W-1:0];
    goeb_d = goeb_w[GPIO_W-1:0];
  end

  // IRQ mask write and lane-masked W1C.
  always_comb begin
    clr_w  = dat_i & lmask;
    mask_w = merge(mask32, dat_i, lmask);
  end

  assign mask_we = wr & (off == OFF_IRQ_MASK);
  assign irq_clr = (wr && off == OFF_IRQ_STATUS) ?
                   clr_w[NUM_IRQ-1:0] : '0;

  // User register writes and their strobe pulses.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      usr_d[i] = usr_q[i];
      uwr_d[i] = 1'b0;
      if (wr && off == OFF_USER_BASE + 32'(i)) begin
        usr_d[i] = merge(usr_q[i], dat_i, lmask);
        uwr_d[i] = 1'b1;
      end
    end
  end

  // Read mux; unmapped offsets return zero.
  always_comb begin
    rdat = '0;
    case (off)
      OFF_GPIO_OUT_LO: rdat = gout64[31:0];
      OFF_GPIO_OUT_HI: rdat = gout64[63:32];
      OFF_GPIO_OEB_LO: rdat = goeb64[31:0];
      OFF_GPIO_OEB_HI: rdat = goeb64[63:32];
      OFF_GPIO_IN_LO:  rdat = gin64[31:0];
      OFF_GPIO_IN_HI:  rdat = gin64[63:32];
      OFF_IRQ_STATUS:  rdat = stat32;
      OFF_IRQ_MASK:    rdat = mask32;
      default: begin
        for (int i = 0; i < NUM_REGS; i++)
          if (off == OFF_USER_BASE + 32'(i))
            rdat = usr_q[i];
      end
    endcase
  end

  // Ack is the registered request; read data rides with it.
  always_comb begin
    ack_d = req;
    dat_d = (req & ~we_i) ? rdat : '0;
  end

  // Bus response registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      uwr_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      uwr_q <= uwr_d;
    end
  end

  // GPIO registers and two-flop input synchroniser.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gout_q  <= '0;
      goeb_q  <= '1;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      gout_q  <= gout_d;
      goeb_q  <= goeb_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
    end
  end

  // User control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++)
        usr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        usr_q[i] <= usr_d[i];
    end
  end

  team_wb_irq_ctrl #(
    .NUM_IRQ(NUM_IRQ)
  ) u_irq (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .src_i     (irq_src_i),
    .mask_we_i (mask_we),
    .mask_wd_i (mask_w[NUM_IRQ-1:0]),
    .clr_i     (irq_clr),
    .status_o  (status),
    .mask_o    (mask),
    .irq_o     (irq_o)
  );

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_usr
    assign usr_reg_o[32*g +: 32] = usr_q[g];
  end

  assign ack_o    = ack_q;
  assign dat_o    = dat_q;
  assign gpio_out = gout_q;
  assign gpio_oeb = goeb_q;
  assign usr_wr_o = uwr_q;

  assign unused = ^{adr_i[1:0], sel_i, gout_w, goeb_w,
                    clr_w, mask_w};

endmodule

// File: tb/tb_team_wb_regbank.sv
// Self-checking bench for team_wb_regbank (default params).
// Honours WB_BYTE_SEL_EN when compiled with it.
module tb_team_wb_regbank;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int NR = 8;
  localparam int NI = 3;
  localparam int GW = 34;
  localparam logic [63:0] GMASK = 64'h3_FFFF_FFFF;

  logic              clk = 0;
  logic              rst = 1;
  logic              ncs = 0;
  logic [31:0]       adr = 0;
  logic [31:0]       wdat = 0;
  logic [3:0]        sel = 4'hF;
  logic              we = 0;
  logic              cyc = 0;
  logic              stb = 0;
  logic              ack;
  logic [31:0]       rdat;
  logic [GW-1:0]     gpio_in = 0;
  logic [GW-1:0]     gpio_out, gpio_oeb;
  logic [NI-1:0]     irq_src = 0;
  logic [NR*32-1:0]  usr_reg;
  logic [NR-1:0]     usr_wr;
  logic [NI-1:0]     irq;

  team_wb_regbank dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .ncs       (ncs),
    .adr_i     (adr),
    .dat_i     (wdat),
    .sel_i     (sel),
    .we_i      (we),
    .cyc_i     (cyc),
    .stb_i     (stb),
    .ack_o     (ack),
    .dat_o     (rdat),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .gpio_oeb  (gpio_oeb),
    .irq_src_i (irq_src),
    .usr_reg_o (usr_reg),
    .usr_wr_o  (usr_wr),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Architectural model of the writable state.
  logic [63:0] m_gout, m_oeb, m_gin;
  logic [31:0] m_mask;
  logic [31:0] m_usr [NR];
  bit          chk_en = 0;

  function automatic void m_reset();
    m_gout = '0;
    m_oeb  = GMASK;
    m_mask = '0;
    for (int i = 0; i < NR; i++) m_usr[i] = '0;
  endfunction

  function automatic logic [31:0] lm(input logic [3:0] s);
    logic [31:0] m;
`ifdef WB_BYTE_SEL_EN
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
`else
    m = '1;
`endif
    return m;
  endfunction

  function automatic logic [31:0] mg(input logic [31:0] o,
    input logic [31:0] d, input logic [3:0] s);
    return (o & ~lm(s)) | (d & lm(s));
  endfunction

  function automatic void model_write(input logic [31:0] off,
    input logic [31:0] d, input logic [3:0] s);
    case (off)
      0: m_gout[31:0]  = mg(m_gout[31:0], d, s);
      1: m_gout[63:32] = mg(m_gout[63:32], d, s);
      2: m_oeb[31:0]   = mg(m_oeb[31:0], d, s);
      3: m_oeb[63:32]  = mg(m_oeb[63:32], d, s);
      7: m_mask = mg(m_mask, d, s) & 32'h7;
      default:
        if (off >= 8 && off < 8 + NR)
          m_usr[off-8] = mg(m_usr[off-8], d, s);
    endcase
    m_gout &= GMASK;
    m_oeb  &= GMASK;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] off);
    logic [31:0] r;
    r = '0;
    case (off)
      0: r = m_gout[31:0];
      1: r = m_gout[63:32];
      2: r = m_oeb[31:0];
      3: r = m_oeb[63:32];
      4: r = m_gin[31:0];
      5: r = m_gin[63:32];
      7: r = m_mask;
      default:
        if (off >= 8 && off < 8 + NR) r = m_usr[off-8];
    endcase
    return r;
  endfunction

  // Continuous compare of the register outputs.
  always @(negedge clk) begin
    logic [255:0] u;
    if (chk_en && !rst) begin
      u = '0;
      for (int i = 0; i < NR; i++) u[32*i +: 32] = m_usr[i];
      chk("gpio_out", gpio_out, m_gout[GW-1:0]);
      chk("gpio_oeb", gpio_oeb, m_oeb[GW-1:0]);
      chk("usr_reg_o", usr_reg, u);
    end
  end

  task automatic xfer(input logic w, input logic [31:0] a,
    input logic [31:0] d, input logic [3:0] s,
    input bit exp_ack, output logic [31:0] rd);
    int waited;
    bit got;
    logic [31:0] off;
    logic [NR-1:0] ew;
    got = 0;
    waited = 0;
    rd = '0;
    off = (a - BASE) >> 2;
    cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
    while (!got && waited < 4) begin
      @(posedge clk); #1;
      waited++;
      if (ack) begin
        got = 1;
        rd = rdat;
        ew = '0;
        if (w && off >= 8 && off < 8 + NR) ew[off-8] = 1'b1;
        chk("usr_wr_pulse", usr_wr, ew);
      end
    end
    cyc = 0; stb = 0; we = 0;
    if (exp_ack) begin
      chk("ack_seen", got, 1);
      chk("ack_latency", waited, 1);
    end else begin
      chk("no_ack", got, 0);
    end
    if (got && w) model_write(off, d, s);
    @(posedge clk); #1;
    chk("ack_one_cycle", ack, 0);
    chk("usr_wr_idle", usr_wr, 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s = 4'hF);
    logic [31:0] x;
    xfer(1, a, d, s, 1, x);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] x;
    xfer(0, a, 0, 4'hF, 1, x);
    chk(nm, x, exp);
  endtask

  logic [31:0] rst_rd [8];
  logic [31:0] junk;
  logic [5:0]  pat;

  initial begin
    rst_rd = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h3,
               32'h0, 32'h0, 32'h0, 32'h0};
    m_reset();
    m_gin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_dat", rdat, 0);
    chk("rst_gpio_out", gpio_out, 0);
    chk("rst_gpio_oeb", gpio_oeb, 34'h3_FFFF_FFFF);
    chk("rst_usr", usr_reg, 0);
    chk("rst_usr_wr", usr_wr, 0);
    chk("rst_irq", irq, 0);
    rst = 0;
    chk_en = 1;
    @(posedge clk); #1;

    for (int o = 0; o < 8; o++)
      rd_chk($sformatf("rst_read_%0d", o), BASE + 32'(4*o),
             rst_rd[o]);

    wr(BASE + 32'h20, 32'hDEAD_BEEF);
    rd_chk("usr0_lit", BASE + 32'h20, 32'hDEAD_BEEF);

    for (int i = 1; i < NR; i++)
      wr(BASE + 32'h20 + 32'(4*i), 32'h1357_0000 + 32'(i * 17));
    for (int i = 0; i < NR; i++)
      rd_chk("usr_read", BASE + 32'h20 + 32'(4*i),
             model_read(32'(8 + i)));

    wr(BASE + 32'h0, 32'hA5A5_0F0F);
    wr(BASE + 32'h4, 32'hFFFF_FFFF);
    chk("gpio_out_lit", gpio_out, 34'h3_A5A5_0F0F);
    rd_chk("gpio_hi_masked", BASE + 32'h4, 32'h3);
    wr(BASE + 32'h8, 32'h0000_00FF);
    wr(BASE + 32'hC, 32'h0);
    chk("gpio_oeb_lit", gpio_oeb, 34'h0_0000_00FF);
    rd_chk("oeb_lo", BASE + 32'h8, model_read(2));

    gpio_in = 34'h2_1234_5678;
    m_gin = 64'h2_1234_5678;
    repeat (3) @(posedge clk);
    #1;
    rd_chk("gpio_in_lo", BASE + 32'h10, 32'h1234_5678);
    rd_chk("gpio_in_hi", BASE + 32'h14, 32'h2);
    wr(BASE + 32'h10, 32'hFFFF_FFFF);
    rd_chk("ro_ignored", BASE + 32'h10, model_read(4));

    wr(BASE + 32'h40, 32'hFFFF);
    rd_chk("unmapped_40", BASE + 32'h40, 32'h0);
    rd_chk("unmapped_fc", BASE + 32'hFC, 32'h0);

    ncs = 1;
    xfer(1, BASE + 32'h24, 32'hBAD0_BAD0, 4'hF, 0, junk);
    xfer(0, BASE + 32'h24, 0, 4'hF, 0, junk);
    ncs = 0;
    rd_chk("ncs_unchanged", BASE + 32'h24, model_read(9));
    xfer(1, BASE + 32'h100, 32'h0, 4'hF, 0, junk);
    xfer(1, BASE - 32'h4, 32'h0, 4'hF, 0, junk);
    rd_chk("oow_unchanged", BASE + 32'h0, 32'hA5A5_0F0F);

    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h1C;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      pat[k] = ack;
    end
    cyc = 0; stb = 0;
    chk("held_stb_pattern", pat, 6'b010101);
    @(posedge clk); #1;

    wr(BASE + 32'h1C, 32'hFFFF_FFFF);
    rd_chk("mask_lit", BASE + 32'h1C, 32'h7);
    irq_src = 3'b010;
    @(posedge clk); #1;
    irq_src = 3'b000;
    @(posedge clk); #1;
    chk("irq_after_edge", irq, 3'b010);
    rd_chk("status_set", BASE + 32'h18, 32'h2);
    irq_src = 3'b010;
    wr(BASE + 32'h18, 32'h2);
    rd_chk("set_wins", BASE + 32'h18, 32'h2);
    chk("irq_set_wins", irq, 3'b010);
    wr(BASE + 32'h18, 32'h2);
    rd_chk("w1c_clear", BASE + 32'h18, 32'h0);
    chk("irq_cleared", irq, 3'b000);
    irq_src = 3'b000;
    wr(BASE + 32'h1C, 32'h3);
    irq_src = 3'b100;
    @(posedge clk); #1;
    irq_src = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("irq_masked", irq, 3'b000);
    rd_chk("status_masked", BASE + 32'h18, 32'h4);
    wr(BASE + 32'h1C, 32'h7);
    @(posedge clk); #1;
    chk("irq_unmasked", irq, 3'b100);
    wr(BASE + 32'h18, 32'h4);
    rd_chk("status_zero", BASE + 32'h18, 32'h0);

    wr(BASE + 32'h24, 32'h1122_3344);
    wr(BASE + 32'h24, 32'h0000_AB00, 4'b0010);
`ifdef WB_BYTE_SEL_EN
    rd_chk("byte_lit", BASE + 32'h24, 32'h1122_AB44);
`else
    rd_chk("byte_lit", BASE + 32'h24, 32'h0000_AB00);
`endif
    rd_chk("byte_model", BASE + 32'h24, model_read(9));

    cyc = 1; stb = 1; we = 1;
    adr = BASE + 32'h28; wdat = 32'h55; sel = 4'hF;
    #2;
    rst = 1;
    #1;
    chk("rst_ack_drop", ack, 0);
    @(posedge clk); #1;
    chk("rst_ack_held", ack, 0);
    chk("rst_usr2", usr_reg[95:64], 32'h0);
    cyc = 0; stb = 0; we = 0;
    m_reset();
    rst = 0;
    @(posedge clk); #1;
    rd_chk("usr2_after_rst", BASE + 32'h28, 32'h0);

    cyc = 1; stb = 1; we = 0; adr = BASE + 32'h8;
    @(posedge clk); #1;
    chk("ack_before_rst", ack, 1);
    #1;
    rst = 1;
    #1;
    chk("ack_drop_live", ack, 0);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    m_reset();
    rst = 0;
    @(posedge clk); #1;
    chk("irq_after_rst", irq, 3'b000);
    rd_chk("oeb_after_rst", BASE + 32'hC, 32'h3);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
